// File: rtl/vending_pkg.sv
// Shared types and coin helpers for the multi-product vending controller.
// Pure declarations; no timing or flow control of its own.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } vstate_t;

  localparam logic [4:0] COIN_5  = 5'd5;
  localparam logic [4:0] COIN_10 = 5'd10;
  localparam logic [4:0] COIN_25 = 5'd25;

  function automatic logic is_valid_coin(input logic [4:0] c);
    return (c == COIN_5) || (c == COIN_10) || (c == COIN_25);
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change picker: largest of 25/10/5 not above the remainder, plus what is left.
// Purely combinational; a zero coin means nothing payable remains.
module vend_change_sel
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] remainder_i,
  output logic [4:0]          coin_o,
  output logic [CREDIT_W-1:0] next_o
);

  always_comb begin
    coin_o = '0;
    next_o = '0;
    if (remainder_i >= CREDIT_W'(COIN_25)) begin
      coin_o = COIN_25;
    end else if (remainder_i >= CREDIT_W'(COIN_10)) begin
      coin_o = COIN_10;
    end else if (remainder_i >= CREDIT_W'(COIN_5)) begin
      coin_o = COIN_5;
    end
    // A residual below the smallest coin is dropped rather than carried.
    if (coin_o != '0) begin
      next_o = remainder_i - CREDIT_W'(coin_o);
    end
  end

endmodule

// File: rtl/vending_mp.sv
// Multi-product vending FSM: saturating credit, per-item stock, greedy change one coin per cycle.
// All outputs registered, 1-cycle response; while busy, coins are rejected and select/cancel ignored.
module vending_mp
  import vending_pkg::*;
#(
  parameter int                          N_ITEMS    = 4,
  parameter int                          CREDIT_W   = 8,
  parameter int                          MAX_CREDIT = 100,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {8'd35, 8'd25, 8'd20, 8'd15},
  parameter int                          STOCK_W    = 4,
  localparam int                         SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [4:0]          coin,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_item,
  input  logic                cancel,
  input  logic                restock_valid,
  input  logic [SEL_W-1:0]    restock_item,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_item,
  output logic                change_valid,
  output logic [4:0]          change_coin,
  output logic                coin_reject,
  output logic [N_ITEMS-1:0]  sold_out,
  output logic                busy
);

  vstate_t             state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic [SEL_W-1:0]    dispense_item_q, dispense_item_d;
  logic                change_valid_q, change_valid_d;
  logic [4:0]          change_coin_q, change_coin_d;
  logic                coin_reject_q, coin_reject_d;
  logic [N_ITEMS-1:0]  sold_out_q, sold_out_d;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];
  logic [STOCK_W-1:0]  stock_d [N_ITEMS];

  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] price;
  logic                sel_in_range;
  logic                sel_in_stock;
  logic                do_pay;
  logic                do_vend;
  logic [4:0]          pay_coin;
  logic [CREDIT_W-1:0] pay_next;

  assign coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin);

  vend_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
    .remainder_i (credit_q),
    .coin_o      (pay_coin),
    .next_o      (pay_next)
  );

  always_comb begin
    price        = '0;
    sel_in_range = 1'b0;
    sel_in_stock = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (SEL_W'(i) == sel_item) begin
        price        = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_in_range = 1'b1;
        sel_in_stock = (stock_q[i] != '0);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    dispense_d      = 1'b0;
    dispense_item_d = '0;
    change_valid_d  = 1'b0;
    change_coin_d   = '0;
    coin_reject_d   = 1'b0;
    do_pay          = 1'b0;
    do_vend         = 1'b0;
    stock_d         = stock_q;
    sold_out_d      = '0;

    case (state_q)
      IDLE, CREDIT: begin
        if (cancel) begin
          do_pay        = (state_q == CREDIT);
          coin_reject_d = coin_valid;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (sel_in_range && sel_in_stock && (credit_q >= price)) begin
            do_vend         = 1'b1;
            state_d         = VEND;
            credit_d        = credit_q - price;
            dispense_d      = 1'b1;
            dispense_item_d = sel_item;
          end
        end else if (coin_valid) begin
          if (!is_valid_coin(coin) || (coin_sum > (CREDIT_W+1)'(MAX_CREDIT))) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end
        end
      end
      VEND, CHANGE: begin
        do_pay        = 1'b1;
        coin_reject_d = coin_valid;
      end
      default: state_d = IDLE;
    endcase

    // Each payout step either emits the next greedy coin or, with nothing payable left, settles to IDLE.
    if (do_pay) begin
      if (pay_coin != '0) begin
        state_d        = CHANGE;
        change_valid_d = 1'b1;
        change_coin_d  = pay_coin;
        credit_d       = pay_next;
      end else begin
        state_d  = IDLE;
        credit_d = '0;
      end
    end

    for (int i = 0; i < N_ITEMS; i++) begin
      if (do_vend && (SEL_W'(i) == sel_item)) begin
        stock_d[i] = stock_q[i] - 1'b1;
      end
      if (restock_valid && (SEL_W'(i) == restock_item)) begin
        stock_d[i] = '1;
      end
      sold_out_d[i] = (stock_d[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      dispense_q      <= 1'b0;
      dispense_item_q <= '0;
      change_valid_q  <= 1'b0;
      change_coin_q   <= '0;
      coin_reject_q   <= 1'b0;
      sold_out_q      <= '0;
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= '1;
      end
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      dispense_q      <= dispense_d;
      dispense_item_q <= dispense_item_d;
      change_valid_q  <= change_valid_d;
      change_coin_q   <= change_coin_d;
      coin_reject_q   <= coin_reject_d;
      sold_out_q      <= sold_out_d;
      stock_q         <= stock_d;
    end
  end

  assign credit        = credit_q;
  assign dispense      = dispense_q;
  assign dispense_item = dispense_item_q;
  assign change_valid  = change_valid_q;
  assign change_coin   = change_coin_q;
  assign coin_reject   = coin_reject_q;
  assign sold_out      = sold_out_q;
  assign busy          = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: doc/vending_mp.md
# vending_mp

Parametrised multi-product vending controller: accepts 5/10/25 coins into a saturating credit register, vends one of `N_ITEMS` products with per-item prices and stock counters, and returns change greedily one coin per cycle. Refunds on cancel, rejects invalid or over-limit coins, and reports sold-out status per item. Sits between the coin-acceptor front end and the dispenser/hopper drivers.

## Interface
- `N_ITEMS`, 4: number of products (≥1).
- `CREDIT_W`, 8: credit and price width, in coin units of 1.
- `MAX_CREDIT`, 100: credit ceiling, < 2**CREDIT_W.
- `PRICES`, {35,25,20,15}: packed `N_ITEMS*CREDIT_W`; item i at bits [i*CREDIT_W +: CREDIT_W]; each price is non-zero and ≤ MAX_CREDIT.
- `STOCK_W`, 4: stock counter width; the full level is 2**STOCK_W-1.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `coin_valid` in 1: coin present this cycle.
- `coin` in 5: coin value.
- `sel_valid` in 1: product selection strobe.
- `sel_item` in $clog2(N_ITEMS): selected item.
- `cancel` in 1: refund request.
- `restock_valid` in 1: refill strobe.
- `restock_item` in $clog2(N_ITEMS): item to refill to full.
- `credit` out CREDIT_W: current credit.
- `dispense` out 1: one-cycle vend pulse.
- `dispense_item` out $clog2(N_ITEMS): item vended, valid with `dispense`.
- `change_valid` out 1: one change coin this cycle.
- `change_coin` out 5: 25, 10 or 5, valid with `change_valid`.
- `coin_reject` out 1: one-cycle pulse; the coin must be returned.
- `sold_out` out N_ITEMS: bit i set when stock[i]==0.
- `busy` out 1: high in VEND or CHANGE.

## Operation
- States (in `vending_pkg::vstate_t`):
  - IDLE: credit==0.
  - CREDIT: credit>0.
  - VEND: one cycle, dispense.
  - CHANGE: pay out remainder.
- Priority in IDLE/CREDIT each cycle: `cancel` > `sel_valid` > `coin_valid`. A lower-priority coin in the same cycle is rejected. A lower-priority select is ignored.
- Coin handling:
  - Valid values are 5, 10 and 25; any other value asserts `coin_reject`.
  - If credit+coin > MAX_CREDIT, assert `coin_reject` and leave credit unchanged.
  - Otherwise credit += coin, and an IDLE machine moves to CREDIT.
- Select:
  - Accepted when credit ≥ PRICES[sel_item] and stock[sel_item] > 0. Next state VEND, credit -= price, stock decrements.
  - Otherwise ignored, with no state change.
  - Out-of-range `sel_item` (N_ITEMS not a power of 2) is ignored.
- Cancel in CREDIT goes to CHANGE with the full credit. Cancel in IDLE is a no-op.
- VEND asserts `dispense`. Next state is CHANGE if credit>0, else IDLE.
- CHANGE pays out one coin per cycle, greedy: the largest of {25,10,5} ≤ credit, and credit decreases by that coin.
  - When credit reaches 0, go to IDLE.
  - A residual credit <5 (cannot occur with valid coins and prices that are multiples of 5) is zeroed and the machine returns to IDLE.
- While `busy`: every `coin_valid` is rejected; `sel_valid` and `cancel` are ignored.
- Restock:
  - Accepted in any state and sets stock[restock_item] to full.
  - If it coincides with a vend decrement of the same item, restock wins.
- Widths:
  - Credit arithmetic uses CREDIT_W+1 bits for the overflow compare.
  - Stock never wraps; a decrement at 0 is impossible because the select check prevents it.

## Timing
- Reset (async on `rst_n` low) sets state IDLE, credit 0, and all stock to full. `dispense`, `change_valid` and `coin_reject` go to 0. `dispense_item` and `change_coin` go to 0. `sold_out` goes to all 0.
- Reset mid-vend or mid-change aborts immediately. The remaining credit is lost by design, since the hopper is resynchronised by firmware.
- All outputs are registered.
- Coin latency: `credit` updates, or `coin_reject` pulses, one cycle after the `coin_valid` edge.
- Select to `dispense`: 1 cycle. `credit` shows the post-price value in the same cycle as `dispense`.
- First change coin appears in the cycle after `dispense`, then one coin per cycle with no gaps.
- Cancel: first change coin appears 1 cycle after `cancel`.
- `sold_out` updates the cycle after a decrement or restock.

## Structure
- `vending_pkg` holds:
  - `vstate_t`
  - coin constants `COIN_5`, `COIN_10`, `COIN_25`
  - function `is_valid_coin`
- Sub-module `vend_change_sel` is a combinational greedy coin picker with `CREDIT_W` parameter. Inputs: remainder. Outputs: coin value, next remainder.
- Top module contains the FSM, the credit register and the stock counter array.

## Test plan
- Insert 10 then 10, select item 0 (price 15) → credit 10 then 20; `dispense`=1, item 0, credit 5; one `change_coin`=5; then IDLE, credit 0.
- Insert 25, 25, 10, then cancel → credit 60; change coins 25, 25, 10 on consecutive cycles; `busy` high for exactly 3 cycles.
- Insert coin=7 → `coin_reject` pulse, credit stays 0. Feed 25×4 to reach credit 100, then a further 5 → rejected, credit stays 100.
- With STOCK_W=1, vend item 1 (price 20) twice with sufficient credit → second select is ignored with `sold_out[1]`=1. Then restock item 1 → `sold_out[1]`=0.
- Same cycle `sel_valid`+`coin_valid` at credit 20, item 1 → vend occurs, coin rejected. A coin inserted during CHANGE is also rejected.
- Drop `rst_n` low for 1 cycle during CHANGE with remaining credit 30 → all outputs 0 and state IDLE immediately; stock full after release.
